// File: rtl/ll_mq_pkg.sv
// Shared types and width helpers for the multi-queue linked-list engine.
package ll_mq_pkg;

  localparam int LLMQ_KEY_W = 64;
  localparam int LLMQ_QID_W = 3;

  typedef enum logic [1:0] {
    LLMQ_OP_ENQ   = 2'd0,
    LLMQ_OP_DEQ   = 2'd1,
    LLMQ_OP_RSVD2 = 2'd2,
    LLMQ_OP_RSVD3 = 2'd3
  } ll_mq_op_e;

  typedef enum logic [1:0] {
    LLMQ_RES_OK     = 2'd0,
    LLMQ_RES_EMPTY  = 2'd1,
    LLMQ_RES_FULL   = 2'd2,
    LLMQ_RES_BAD_OP = 2'd3
  } ll_mq_rescode_e;

  typedef enum logic [2:0] {
    LLMQ_ST_INIT     = 3'd0,
    LLMQ_ST_IDLE     = 3'd1,
    LLMQ_ST_DEQ_RD   = 3'd2,
    LLMQ_ST_DEQ_WAIT = 3'd3,
    LLMQ_ST_RESP     = 3'd4
  } ll_mq_state_e;

  typedef struct packed {
    ll_mq_op_e               opcode;
    logic [LLMQ_QID_W-1:0]   qid;
    logic [LLMQ_KEY_W-1:0]   key;
  } ll_mq_cmd_t;

  typedef struct packed {
    ll_mq_op_e               opcode;
    logic [LLMQ_QID_W-1:0]   qid;
    logic [LLMQ_KEY_W-1:0]   key;
    ll_mq_rescode_e          rescode;
  } ll_mq_res_t;

  function automatic int llmq_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ll_mq_free_fifo.sv
// Free-node pointer FIFO; after reset it loads 0..DEPTH-1 one entry per cycle
// before reporting init_done_o. Push and pop may occur in the same cycle.
module ll_mq_free_fifo
  import ll_mq_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [$clog2(DEPTH)-1:0] push_ptr_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH)-1:0] pop_ptr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     init_done_o
);
  localparam int AW = llmq_idx_w(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, idx_q, idx_d, wdata_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, we_s, push_ok_s, pop_ok_s;

  // Init sequencer owns the write port until every node index is loaded.
  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    we_s      = 1'b0;
    wdata_s   = push_ptr_i;
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (!done_q) begin
      we_s    = 1'b1;
      wdata_s = idx_q;
      wr_d    = wr_q + AW'(1);
      idx_d   = idx_q + AW'(1);
      cnt_d   = cnt_q + CW'(1);
      done_d  = (idx_q == AW'(DEPTH - 1));
    end else begin
      push_ok_s = push_i;
      pop_ok_s  = pop_i && (cnt_q != '0);
      we_s      = push_ok_s;
      if (push_ok_s) wr_d = wr_q + AW'(1);
      else           wr_d = wr_q;
      if (pop_ok_s) rd_d = rd_q + AW'(1);
      else          rd_d = rd_q;
      cnt_d = cnt_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_s) mem[wr_q] <= wdata_s;
  end

  assign pop_ptr_o   = mem[rd_q];
  assign count_o     = cnt_q;
  assign empty_o     = (cnt_q == '0);
  assign init_done_o = done_q;

endmodule

// File: rtl/ll_multi_queue_engine.sv
// NUM_QUEUES FIFO queues as linked lists in one shared node RAM, one command at a time.
// Optional LLMQ_STATS_EN adds saturating OK-ENQ / OK-DEQ / error result counters.
module ll_multi_queue_engine
  import ll_mq_pkg::*;
#(
  parameter int KEY_W       = 64,
  parameter int DEPTH       = 256,
  parameter int NUM_QUEUES  = 8,
  parameter int RAM_LATENCY = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     cmd_valid_i,
  output logic                                     cmd_ready_o,
  input  logic [1:0]                               cmd_opcode_i,
  input  logic [$clog2(NUM_QUEUES)-1:0]            cmd_qid_i,
  input  logic [KEY_W-1:0]                         cmd_key_i,
  output logic                                     res_valid_o,
  input  logic                                     res_ready_i,
  output logic [1:0]                               res_opcode_o,
  output logic [$clog2(NUM_QUEUES)-1:0]            res_qid_o,
  output logic [KEY_W-1:0]                         res_key_o,
  output logic [1:0]                               res_rescode_o,
  output logic [NUM_QUEUES*($clog2(DEPTH)+1)-1:0]  q_count_o,
  output logic [$clog2(DEPTH):0]                   free_count_o,
  output logic                                     init_done_o
`ifdef LLMQ_STATS_EN
  ,
  output logic [31:0]                              stat_enq_o,
  output logic [31:0]                              stat_deq_o,
  output logic [31:0]                              stat_err_o
`endif
);
  localparam int QW = llmq_idx_w(NUM_QUEUES);
  localparam int AW = llmq_idx_w(DEPTH);
  localparam int CW = AW + 1;

  ll_mq_state_e  state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [1:0]    res_opcode_q, res_opcode_d, res_rescode_q, res_rescode_d;
  logic [QW-1:0] res_qid_q, res_qid_d;
  logic [KEY_W-1:0] res_key_q, res_key_d;
  logic [AW-1:0] head_q [NUM_QUEUES];
  logic [AW-1:0] head_d [NUM_QUEUES];
  logic [AW-1:0] tail_q [NUM_QUEUES];
  logic [AW-1:0] tail_d [NUM_QUEUES];
  logic [CW-1:0] count_q [NUM_QUEUES];
  logic [CW-1:0] count_d [NUM_QUEUES];

  logic          fifo_push_s, fifo_pop_s, fifo_empty_s, fifo_init_done_s;
  logic [AW-1:0] fifo_push_ptr_s, fifo_pop_ptr_s;
  logic [CW-1:0] fifo_count_s;

  logic [KEY_W-1:0] key_ram [DEPTH];
  logic [AW-1:0]    next_ram [DEPTH];
  logic             key_we_s, next_we_s;
  logic [AW-1:0]    next_wa_s, rd_addr_s;
  logic [KEY_W-1:0] key_p1_q, key_p2_q, rd_key_s;
  logic [AW-1:0]    next_p1_q, next_p2_q, rd_next_s;

  ll_mq_free_fifo #(.DEPTH(DEPTH)) u_free_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push_s),
    .push_ptr_i  (fifo_push_ptr_s),
    .pop_i       (fifo_pop_s),
    .pop_ptr_o   (fifo_pop_ptr_s),
    .count_o     (fifo_count_s),
    .empty_o     (fifo_empty_s),
    .init_done_o (fifo_init_done_s)
  );

  // Separate key/next write ports let ENQ write the new node and relink the old tail together.
  always_ff @(posedge clk_i) begin
    if (key_we_s)  key_ram[fifo_pop_ptr_s] <= cmd_key_i;
    if (next_we_s) next_ram[next_wa_s]     <= fifo_pop_ptr_s;
    key_p1_q  <= key_ram[rd_addr_s];
    next_p1_q <= next_ram[rd_addr_s];
    key_p2_q  <= key_p1_q;
    next_p2_q <= next_p1_q;
  end

  assign rd_key_s  = (RAM_LATENCY == 1) ? key_p1_q : key_p2_q;
  assign rd_next_s = (RAM_LATENCY == 1) ? next_p1_q : next_p2_q;

  always_comb begin
    state_d         = state_q;
    res_valid_d     = res_valid_q;
    res_opcode_d    = res_opcode_q;
    res_qid_d       = res_qid_q;
    res_key_d       = res_key_q;
    res_rescode_d   = res_rescode_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    fifo_pop_s      = 1'b0;
    fifo_push_s     = 1'b0;
    fifo_push_ptr_s = head_q[res_qid_q];
    key_we_s        = 1'b0;
    next_we_s       = 1'b0;
    next_wa_s       = tail_q[cmd_qid_i];
    rd_addr_s       = head_q[cmd_qid_i];
    case (state_q)
      LLMQ_ST_INIT: begin
        if (fifo_init_done_s) state_d = LLMQ_ST_IDLE;
        else                  state_d = LLMQ_ST_INIT;
      end
      LLMQ_ST_IDLE: begin
        if (cmd_ready_q && cmd_valid_i) begin
          res_opcode_d  = cmd_opcode_i;
          res_qid_d     = cmd_qid_i;
          res_key_d     = '0;
          res_rescode_d = LLMQ_RES_OK;
          res_valid_d   = 1'b1;
          state_d       = LLMQ_ST_RESP;
          case (cmd_opcode_i)
            LLMQ_OP_ENQ: begin
              res_key_d = cmd_key_i;
              if (fifo_empty_s) begin
                res_rescode_d = LLMQ_RES_FULL;
              end else begin
                fifo_pop_s = 1'b1;
                key_we_s   = 1'b1;
                if (count_q[cmd_qid_i] != '0) next_we_s = 1'b1;
                else                          head_d[cmd_qid_i] = fifo_pop_ptr_s;
                tail_d[cmd_qid_i]  = fifo_pop_ptr_s;
                count_d[cmd_qid_i] = count_q[cmd_qid_i] + CW'(1);
              end
            end
            LLMQ_OP_DEQ: begin
              if (count_q[cmd_qid_i] == '0) begin
                res_rescode_d = LLMQ_RES_EMPTY;
              end else begin
                res_valid_d = 1'b0;
                if (RAM_LATENCY > 1) state_d = LLMQ_ST_DEQ_RD;
                else                 state_d = LLMQ_ST_DEQ_WAIT;
              end
            end
            default: res_rescode_d = LLMQ_RES_BAD_OP;
          endcase
        end else begin
          state_d = LLMQ_ST_IDLE;
        end
      end
      LLMQ_ST_DEQ_RD: state_d = LLMQ_ST_DEQ_WAIT;
      LLMQ_ST_DEQ_WAIT: begin
        // Tail is left stale when the queue drains; the next ENQ rewrites head and tail.
        head_d[res_qid_q]  = rd_next_s;
        count_d[res_qid_q] = count_q[res_qid_q] - CW'(1);
        fifo_push_s        = 1'b1;
        res_key_d          = rd_key_s;
        res_rescode_d      = LLMQ_RES_OK;
        res_valid_d        = 1'b1;
        state_d            = LLMQ_ST_RESP;
      end
      LLMQ_ST_RESP: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = LLMQ_ST_IDLE;
        end else begin
          state_d = LLMQ_ST_RESP;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = LLMQ_ST_INIT;
      end
    endcase
    cmd_ready_d = (state_d == LLMQ_ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= LLMQ_ST_INIT;
      cmd_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_opcode_q  <= 2'd0;
      res_qid_q     <= '0;
      res_key_q     <= '0;
      res_rescode_q <= 2'd0;
      head_q        <= '{default: '0};
      tail_q        <= '{default: '0};
      count_q       <= '{default: '0};
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      res_valid_q   <= res_valid_d;
      res_opcode_q  <= res_opcode_d;
      res_qid_q     <= res_qid_d;
      res_key_q     <= res_key_d;
      res_rescode_q <= res_rescode_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    q_count_o = '0;
    for (int i = 0; i < NUM_QUEUES; i++) q_count_o[i*CW +: CW] = count_q[i];
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign res_valid_o   = res_valid_q;
  assign res_opcode_o  = res_opcode_q;
  assign res_qid_o     = res_qid_q;
  assign res_key_o     = res_key_q;
  assign res_rescode_o = res_rescode_q;
  assign free_count_o  = fifo_count_s;
  assign init_done_o   = fifo_init_done_s;

`ifdef LLMQ_STATS_EN
  logic [31:0] stat_enq_q, stat_enq_d, stat_deq_q, stat_deq_d, stat_err_q, stat_err_d;
  logic        res_rise_s;

  // Each result is counted once, on the cycle its valid is first raised.
  always_comb begin
    res_rise_s = res_valid_d && !res_valid_q;
    stat_enq_d = stat_enq_q;
    stat_deq_d = stat_deq_q;
    stat_err_d = stat_err_q;
    if (res_rise_s) begin
      if (res_rescode_d != LLMQ_RES_OK) begin
        if (stat_err_q != 32'hFFFF_FFFF) stat_err_d = stat_err_q + 32'd1;
        else                             stat_err_d = stat_err_q;
      end else if (res_opcode_d == LLMQ_OP_ENQ) begin
        if (stat_enq_q != 32'hFFFF_FFFF) stat_enq_d = stat_enq_q + 32'd1;
        else                             stat_enq_d = stat_enq_q;
      end else begin
        if (stat_deq_q != 32'hFFFF_FFFF) stat_deq_d = stat_deq_q + 32'd1;
        else                             stat_deq_d = stat_deq_q;
      end
    end else begin
      stat_enq_d = stat_enq_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_enq_q <= 32'd0;
      stat_deq_q <= 32'd0;
      stat_err_q <= 32'd0;
    end else begin
      stat_enq_q <= stat_enq_d;
      stat_deq_q <= stat_deq_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_enq_o = stat_enq_q;
  assign stat_deq_o = stat_deq_q;
  assign stat_err_o = stat_err_q;
`endif

endmodule

// File: tb/tb_ll_multi_queue_engine.sv
// Scoreboard bench: per-queue SV queues model the engine; a monitor checks every result.
`timescale 1ns/1ps
module tb_ll_multi_queue_engine;
  localparam int KEY_W = 64;
  localparam int DEPTH = 256;
  localparam int NQ    = 8;
  localparam int LAT   = 2;
  localparam int QW    = 3;
  localparam int CW    = 9;
  localparam logic [1:0] OP_ENQ = 2'd0, OP_DEQ = 2'd1;
  localparam logic [1:0] RC_OK = 2'd0, RC_EMPTY = 2'd1, RC_FULL = 2'd2, RC_BAD = 2'd3;

  typedef logic [NQ*CW-1:0] val_t;
  typedef struct {
    logic [1:0]       op;
    logic [QW-1:0]    qid;
    logic [KEY_W-1:0] key;
    logic [1:0]       rc;
    int               lat;
    logic [CW-1:0]    freec;
    val_t             qc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic cmd_valid_i = 1'b0;
  logic [1:0] cmd_opcode_i = 2'd0;
  logic [QW-1:0] cmd_qid_i = '0;
  logic [KEY_W-1:0] cmd_key_i = '0;
  logic res_ready_i = 1'b1;
  logic cmd_ready_o, res_valid_o, init_done_o;
  logic [1:0] res_opcode_o, res_rescode_o;
  logic [QW-1:0] res_qid_o;
  logic [KEY_W-1:0] res_key_o;
  val_t q_count_o;
  logic [CW-1:0] free_count_o;
`ifdef LLMQ_STATS_EN
  logic [31:0] stat_enq_o, stat_deq_o, stat_err_o;
`endif

  ll_multi_queue_engine #(.KEY_W(KEY_W), .DEPTH(DEPTH), .NUM_QUEUES(NQ), .RAM_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_qid_i(cmd_qid_i), .cmd_key_i(cmd_key_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_opcode_o(res_opcode_o),
    .res_qid_o(res_qid_o), .res_key_o(res_key_o), .res_rescode_o(res_rescode_o),
    .q_count_o(q_count_o), .free_count_o(free_count_o), .init_done_o(init_done_o)
`ifdef LLMQ_STATS_EN
    , .stat_enq_o(stat_enq_o), .stat_deq_o(stat_deq_o), .stat_err_o(stat_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int accept_cyc = 0;
  bit rand_bp = 1'b0;
  exp_t sb[$];
  logic [KEY_W-1:0] mq [NQ][$];

  task automatic chk(input string name, input val_t act, input val_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < NQ; i++) t += mq[i].size();
    return t;
  endfunction

  function automatic val_t model_qc();
    val_t v = '0;
    for (int i = 0; i < NQ; i++) v[i*CW +: CW] = CW'(mq[i].size());
    return v;
  endfunction

  // Issue one command: the model decides the outcome, then the expectation is queued.
  task automatic do_cmd(input logic [1:0] op, input int q, input logic [KEY_W-1:0] k);
    exp_t e;
    int n = 0;
    while (!cmd_ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
    if (!cmd_ready_o) begin
      chk("cmd_ready_timeout", val_t'(cmd_ready_o), val_t'(1));
      return;
    end
    e.op = op; e.qid = q[QW-1:0]; e.key = '0; e.rc = RC_OK; e.lat = 0;
    case (op)
      OP_ENQ: begin
        e.key = k;
        if (model_total() == DEPTH) e.rc = RC_FULL;
        else mq[q].push_back(k);
      end
      OP_DEQ: begin
        if (mq[q].size() == 0) e.rc = RC_EMPTY;
        else begin e.key = mq[q].pop_front(); e.lat = LAT; end
      end
      default: e.rc = RC_BAD;
    endcase
    e.freec = CW'(DEPTH - model_total());
    e.qc = model_qc();
    sb.push_back(e);
    cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_qid_i = q[QW-1:0]; cmd_key_i = k;
    @(posedge clk_i); #1;
    accept_cyc = cyc;
    cmd_valid_i = 1'b0;
    cmd_key_i = {$urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !cmd_ready_o) && n < 300) begin @(posedge clk_i); #1; n++; end
    chk("drain", val_t'(sb.size()), val_t'(0));
  endtask

  task automatic do_reset();
    int n = 0;
    rst_i = 1'b1; cmd_valid_i = 1'b0;
    sb.delete();
    for (int i = 0; i < NQ; i++) mq[i].delete();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_res_valid", val_t'(res_valid_o), val_t'(0));
    chk("rst_cmd_ready", val_t'(cmd_ready_o), val_t'(0));
    chk("rst_init_done", val_t'(init_done_o), val_t'(0));
    chk("rst_free_count", val_t'(free_count_o), val_t'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    do begin @(posedge clk_i); #1; n++; end while (!init_done_o && n < 1000);
    chk("init_cycles", val_t'(n), val_t'(DEPTH));
    chk("init_free_count", val_t'(free_count_o), val_t'(DEPTH));
    chk("init_q_count", q_count_o, val_t'(0));
  endtask

  function automatic int nonempty_q();
    for (int i = 0; i < NQ; i++) if (mq[i].size() != 0) return i;
    return 0;
  endfunction

  // Monitor: latency on the rising edge of valid, full comparison on the handshake.
  initial begin : monitor
    exp_t e;
    logic prev_v = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) prev_v = 1'b0;
      else begin
        if (res_valid_o && !prev_v && sb.size() > 0)
          chk("latency", val_t'(cyc - accept_cyc), val_t'(sb[0].lat));
        if (res_valid_o && res_ready_i) begin
          if (sb.size() == 0) chk("unexpected_result", val_t'(res_valid_o), val_t'(0));
          else begin
            e = sb.pop_front();
            chk("res_opcode", val_t'(res_opcode_o), val_t'(e.op));
            chk("res_qid", val_t'(res_qid_o), val_t'(e.qid));
            chk("res_key", val_t'(res_key_o), val_t'(e.key));
            chk("res_rescode", val_t'(res_rescode_o), val_t'(e.rc));
            chk("free_count", val_t'(free_count_o), val_t'(e.freec));
            chk("q_count", q_count_o, e.qc);
          end
        end
        prev_v = res_valid_o;
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rand_bp) res_ready_i = ($urandom_range(0, 3) != 0);
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int q;
    int r;
    logic [KEY_W-1:0] kexp;
    do_reset();

    // Basic FIFO order on q3 and the empty case.
    do_cmd(OP_ENQ, 3, 64'hA);
    do_cmd(OP_ENQ, 3, 64'hB);
    do_cmd(OP_ENQ, 3, 64'hC);
    repeat (4) do_cmd(OP_DEQ, 3, 64'h0);

    // Interleaved queues keep independent order.
    for (int i = 0; i < 10; i++) begin
      do_cmd(OP_ENQ, 0, {$urandom, $urandom});
      do_cmd(OP_ENQ, 1, {$urandom, $urandom});
    end
    for (int i = 0; i < 10; i++) begin
      do_cmd(OP_DEQ, 0, 64'h0);
      do_cmd(OP_DEQ, 1, 64'h0);
    end
    wait_drain();

    // Random traffic with result back-pressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      q = $urandom_range(0, NQ - 1);
      if (r < 50)      do_cmd(OP_ENQ, q, {$urandom, $urandom});
      else if (r < 90) do_cmd(OP_DEQ, q, 64'h0);
      else             do_cmd(2'($urandom_range(2, 3)), q, {$urandom, $urandom});
    end
    wait_drain();
    rand_bp = 1'b0;
    res_ready_i = 1'b1;

    // Exhaust the shared node pool, then free one node and reuse it.
    while (model_total() < DEPTH) do_cmd(OP_ENQ, $urandom_range(0, NQ - 1), {$urandom, $urandom});
    do_cmd(OP_ENQ, 5, 64'hDEAD_BEEF);
    do_cmd(OP_DEQ, nonempty_q(), 64'h0);
    do_cmd(OP_ENQ, 6, 64'h1234_5678);
    wait_drain();

    // Held result stays stable and blocks new commands.
    q = nonempty_q();
    kexp = mq[q][0];
    res_ready_i = 1'b0;
    do_cmd(OP_DEQ, q, 64'h0);
    r = 0;
    while (!res_valid_o && r < 20) begin @(posedge clk_i); #1; r++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", val_t'(res_valid_o), val_t'(1));
      chk("hold_cmd_ready", val_t'(cmd_ready_o), val_t'(0));
      chk("hold_key", val_t'(res_key_o), val_t'(kexp));
      @(posedge clk_i); #1;
    end
    res_ready_i = 1'b1;
    do_cmd(2'd3, 2, 64'h55);
    wait_drain();

    // Reset while a DEQ is waiting on the RAM: no result, everything rebuilt.
    q = nonempty_q();
    do_cmd(OP_DEQ, q, 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    do_reset();
    do_cmd(OP_DEQ, q, 64'h0);
    do_cmd(OP_ENQ, q, 64'h77);
    do_cmd(OP_DEQ, q, 64'h0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
